// File: rtl/mux_sel_reg.sv
// mux_sel_reg: registered N-way datapath multiplexer.
// A select register is loaded by a strobe and keeps its value until the next
// load. The output goes through a STAGES-deep pipeline that hold can freeze,
// and a sticky error flag marks a load with a select code that has no input.
module mux_sel_reg #(
    parameter int WIDTH  = 32,
    parameter int N_IN   = 4,
    parameter int SEL_W  = 2,
    parameter int STAGES = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_IN*WIDTH-1:0]   entradas,
    input  logic [SEL_W-1:0]        controle,
    input  logic                    carrega,
    input  logic                    hold,
    output logic [WIDTH-1:0]        saida,
    output logic                    valido,
    output logic                    erro
);

    logic [SEL_W-1:0]               sel_reg;
    logic [SEL_W-1:0]               sel_eff;
    logic                           legal;
    logic [WIDTH-1:0]               mux_out;
    logic [STAGES-1:0][WIDTH-1:0]   pipe;
    logic [STAGES-1:0]              vld_sr;
    logic                           erro_r;

    // Codes at or above N_IN have no input behind them and are never stored.
    assign legal = (32'(controle) < 32'(N_IN));

    // A legal load takes effect on the same edge (bypass); otherwise use the stored select.
    always_comb begin
        sel_eff = sel_reg;
        if (carrega && !hold && legal)
            sel_eff = controle;
    end

    // Compare-and-pick over the real inputs only, so no index can fall outside entradas.
    always_comb begin
        mux_out = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel_eff == SEL_W'(k))
                mux_out = entradas[k*WIDTH +: WIDTH];
        end
    end

    // Select register, error flag, data pipeline and valid shifter; reset beats hold beats load.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sel_reg <= '0;
            erro_r  <= 1'b0;
            pipe    <= '0;
            vld_sr  <= '0;
        end else if (!hold) begin
            if (carrega) begin
                if (legal) begin
                    sel_reg <= controle;
                    erro_r  <= 1'b0;
                end else begin
                    erro_r  <= 1'b1;
                end
            end
            pipe[0] <= mux_out;
            for (int i = 1; i < STAGES; i++)
                pipe[i] <= pipe[i-1];
            vld_sr <= (vld_sr << 1) | STAGES'(1);
        end
    end

    assign saida  = pipe[STAGES-1];
    assign valido = vld_sr[STAGES-1];
    assign erro   = erro_r;

endmodule

// File: tb/tb_mux_sel_reg.sv
// Bench for mux_sel_reg: a table of per-edge vectors with hand-derived expected
// outputs, a scoreboard fed from an independent select model, a separate
// 3-input instance for illegal-select cases, and a random phase.
module tb_mux_sel_reg;

    localparam int W  = 32;
    localparam int ST = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           carrega;
    logic           hold;
    logic [1:0]     controle;
    logic [4*W-1:0] entradas;
    logic [W-1:0]   saida, saida3;
    logic           valido, erro, valido3, erro3;

    int             checks   = 0;
    int             failures = 0;
    logic [1:0]     msel     = 2'd0;
    logic [W-1:0]   sb_q[$];

    typedef struct {
        logic         rst;
        logic         hld;
        logic         ld;
        logic [1:0]   ctl;
        logic [W-1:0] d0, d1, d2, d3;
        logic         chk;
        logic [W-1:0] exp_sd;
        logic         exp_v;
        logic         exp_e;
    } vec_t;

    vec_t tbl[$];

    always #5 clock = ~clock;

    mux_sel_reg #(.WIDTH(W), .N_IN(4), .SEL_W(2), .STAGES(ST)) dut (
        .clock(clock), .reset(reset), .entradas(entradas), .controle(controle),
        .carrega(carrega), .hold(hold), .saida(saida), .valido(valido), .erro(erro)
    );

    mux_sel_reg #(.WIDTH(W), .N_IN(3), .SEL_W(2), .STAGES(ST)) dut3 (
        .clock(clock), .reset(reset), .entradas(entradas[3*W-1:0]), .controle(controle),
        .carrega(carrega), .hold(hold), .saida(saida3), .valido(valido3), .erro(erro3)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic hld, input logic ld,
                                input logic [1:0] ctl,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] d,
                                input logic chk, input logic [W-1:0] sd,
                                input logic vl, input logic er);
        vec_t t;
        t.rst = rst; t.hld = hld; t.ld = ld; t.ctl = ctl;
        t.d0 = a; t.d1 = b; t.d2 = c; t.d3 = d;
        t.chk = chk; t.exp_sd = sd; t.exp_v = vl; t.exp_e = er;
        return t;
    endfunction

    // One clock edge: drive at negedge, update model at posedge, compare 1 time unit later.
    task automatic step(input logic rst, input logic hld, input logic ld, input logic [1:0] ctl,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d);
        logic [1:0]   eff;
        logic [W-1:0] x;
        @(negedge clock);
        reset    = rst;
        hold     = hld;
        carrega  = ld;
        controle = ctl;
        entradas = {d, c, b, a};
        @(posedge clock);
        if (!rst) begin
            msel = 2'd0;
            sb_q.delete();
        end else if (!hld) begin
            eff = msel;
            if (ld) begin
                eff  = ctl;
                msel = ctl;
            end
            case (eff)
                2'd0:    x = a;
                2'd1:    x = b;
                2'd2:    x = c;
                default: x = d;
            endcase
            sb_q.push_back(x);
        end
        #1;
        if (rst && !hld && sb_q.size() == ST) begin
            x = sb_q.pop_front();
            check("sb_saida", saida, x);
            check("sb_valido", 32'(valido), 32'd1);
        end
    endtask

    initial begin
        reset = 1'b0; hold = 1'b0; carrega = 1'b0; controle = 2'd0; entradas = '0;

        // reset and valid timing
        tbl.push_back(mk(0,0,0,0, 'hA0,1,2,3, 1, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 'hA0,1,2,3, 1, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 'hA0,1,2,3, 1, 0,0,0));
        tbl.push_back(mk(1,0,0,0, 'hA0,1,2,3, 1, 0,0,0));
        tbl.push_back(mk(1,0,0,0, 'hA0,1,2,3, 1, 'hA0,1,0));
        // load with bypass, select persists, data change follows
        tbl.push_back(mk(1,0,1,2, 11,22,33,44, 1, 'hA0,1,0));
        tbl.push_back(mk(1,0,0,0, 11,22,33,44, 1, 33,1,0));
        tbl.push_back(mk(1,0,0,0, 11,22,55,44, 1, 33,1,0));
        tbl.push_back(mk(1,0,0,0, 11,22,55,44, 1, 55,1,0));
        // stream on D0, hold for 4 edges with an ignored load
        tbl.push_back(mk(1,0,1,0, 1,22,55,44, 1, 55,1,0));
        tbl.push_back(mk(1,0,0,0, 2,22,55,44, 1, 1,1,0));
        tbl.push_back(mk(1,0,0,0, 3,22,55,44, 1, 2,1,0));
        tbl.push_back(mk(1,1,0,0, 4,22,55,44, 1, 2,1,0));
        tbl.push_back(mk(1,1,1,3, 4,22,55,44, 1, 2,1,0));
        tbl.push_back(mk(1,1,0,0, 4,22,55,44, 1, 2,1,0));
        tbl.push_back(mk(1,1,0,0, 4,22,55,44, 1, 2,1,0));
        tbl.push_back(mk(1,0,0,0, 4,22,55,44, 1, 3,1,0));
        tbl.push_back(mk(1,0,0,0, 5,22,55,44, 1, 4,1,0));
        tbl.push_back(mk(1,0,0,0, 6,22,55,44, 1, 5,1,0));
        // reset mid-stream with load and hold asserted
        tbl.push_back(mk(1,0,1,3, 'hD0,22,55,44, 1, 6,1,0));
        tbl.push_back(mk(1,0,0,0, 'hD0,22,55,44, 1, 44,1,0));
        tbl.push_back(mk(0,1,1,1, 'hD0,22,55,44, 1, 0,0,0));
        tbl.push_back(mk(1,0,0,0, 'hD0,22,55,44, 1, 0,0,0));
        tbl.push_back(mk(1,0,0,0, 'hD0,22,55,44, 1, 'hD0,1,0));
        // back-to-back loads
        tbl.push_back(mk(1,0,1,1, 'hD0,22,55,44, 1, 'hD0,1,0));
        tbl.push_back(mk(1,0,1,3, 'hD0,22,55,44, 1, 22,1,0));
        tbl.push_back(mk(1,0,0,0, 'hD0,22,55,44, 1, 44,1,0));
        tbl.push_back(mk(1,0,0,0, 'hD0,22,55,44, 1, 44,1,0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].hld, tbl[i].ld, tbl[i].ctl,
                 tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_saida", i), saida, tbl[i].exp_sd);
                check($sformatf("vec%0d_valido", i), 32'(valido), 32'(tbl[i].exp_v));
                check($sformatf("vec%0d_erro", i), 32'(erro), 32'(tbl[i].exp_e));
            end
        end

        // illegal select on the 3-input instance
        step(0,0,0,0, 11,7,33,44);
        check("ill_rst_saida", saida3, 0);
        check("ill_rst_valido", 32'(valido3), 0);
        check("ill_rst_erro", 32'(erro3), 0);
        step(1,0,1,1, 11,7,33,44);
        check("ill_load1_erro", 32'(erro3), 0);
        step(1,0,1,3, 11,7,33,44);
        check("ill_load3_erro", 32'(erro3), 1);
        step(1,0,0,0, 11,7,33,44);
        check("ill_hold_sel_saida", saida3, 7);
        check("ill_sticky_erro", 32'(erro3), 1);
        check("ill_valido", 32'(valido3), 1);
        step(1,0,0,0, 11,7,33,44);
        check("ill_sticky2_saida", saida3, 7);
        check("ill_sticky2_erro", 32'(erro3), 1);
        step(1,0,1,0, 11,7,33,44);
        check("ill_clear_erro", 32'(erro3), 0);
        check("ill_clear_saida", saida3, 7);
        step(1,0,0,0, 11,7,33,44);
        check("ill_d0_saida", saida3, 11);
        check("ill_d0_erro", 32'(erro3), 0);

        // random traffic against the scoreboard
        for (int n = 0; n < 80; n++) begin
            step(1'b1, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
            check("rnd_erro", 32'(erro), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_sel_reg.md
Name: mux_sel_reg

Overview:
- Parametrised, registered N-way datapath multiplexer.
- Successor to the 2:1 combinational datapath mux: generalised width and input count.
- Adds a latched select register with a load strobe, a configurable output pipeline with freeze (hold), a valid flag and an illegal-select error flag.
- Sits in the multicycle datapath between register/ALU sources and consumers; the control unit pulses a select once and the choice persists across states.

Parameters:
- WIDTH, 32, data width in bits.
- N_IN, 4, number of data inputs (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_IN.
- STAGES, 1, output pipeline depth (1..3); 0 is not permitted.

Ports:
- clock  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clock rising edge).
- entradas  input  N_IN*WIDTH  packed data inputs; input k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
- controle  input  SEL_W  new select value, used only when carrega=1.
- carrega  input  1  select-load strobe.
- hold  input  1  freezes the select register, the pipeline and the valid shift register.
- saida  output  WIDTH  selected data, registered.
- valido  output  1  saida holds data captured after reset.
- erro  output  1  sticky illegal-select flag.

Behaviour:
- Reset (reset=0 at an edge): sel_reg=0, all pipeline stages=0, valid shift register=0. Consequently saida=0, valido=0, erro=0. Reset has priority over hold and carrega. Reset mid-stream discards all in-flight data.
- Legal load: carrega=1, hold=0, controle<N_IN.
  - sel_reg <= controle.
  - erro <= 0.
  - Bypass: the effective select for this same edge is controle, so stage 1 captures entradas[controle] at this edge.
- Illegal load: carrega=1, hold=0, controle>=N_IN.
  - sel_reg is unchanged.
  - erro <= 1 and stays 1 until a legal load or reset.
  - The effective select is the old sel_reg.
- No load (carrega=0, hold=0): effective select = sel_reg.
- Pipeline, on each edge with hold=0:
  - stage1 <= entradas[sel_eff].
  - stage[i] <= stage[i-1] for i=2..STAGES.
  - saida = stage[STAGES].
  - Latency from entradas/controle to saida: STAGES clock edges with hold=0.
- Valid: a STAGES-bit shift register. Each hold=0 edge shifts in 1; valido = its last bit. valido rises exactly STAGES non-held edges after reset deasserts, then stays 1 until reset.
- Hold (hold=1, reset=1):
  - All state is frozen: sel_reg, stages, valid bits, erro.
  - carrega is ignored (no load, no erro change).
  - saida and valido are stable.
- Unused select codes (N_IN < 2**SEL_W) can never reach sel_reg. There is no X propagation; the selection logic must not index outside entradas.
- Simultaneous carrega=1 and hold=1: hold wins.

Test Plan (WIDTH=32, N_IN=4, SEL_W=2, STAGES=2):
1. Reset and valid timing.
   - Stimulus: hold reset=0 for 3 edges, then release; keep carrega=0, hold=0, entradas[0]=32'hA0.
   - Response: saida=0 and valido=0 during reset; valido=1 after the 2nd edge following release; saida=32'hA0 at that point.
2. Load with bypass.
   - Stimulus: entradas = {D0=11, D1=22, D2=33, D3=44}; pulse carrega=1 with controle=2 for one edge.
   - Response: saida=33 two edges later; sel_reg stays 2 after carrega drops; a later change of D2 to 55 appears at saida 2 edges after the change.
3. Illegal select.
   - Stimulus: configure N_IN=3 with SEL_W=2, sel_reg=1, D1=7; pulse carrega=1 with controle=3.
   - Response: erro=1 on the next edge; selection stays D1, so saida=7.
   - Follow-up: a legal load with controle=0 clears erro on the edge it is captured.
4. Hold freeze.
   - Stimulus: stream changing D0 values (1, 2, 3, ...) with sel=0; assert hold=1 for 4 edges, and pulse carrega with controle=3 during the hold.
   - Response: saida and valido stay constant during the hold; sel_reg stays 0 (load ignored); the stream resumes in order after hold drops, with no values skipped or duplicated beyond the frozen word.
5. Reset mid-stream.
   - Stimulus: with valido=1 and sel_reg=3, pulse reset=0 for one edge while carrega=1 and hold=1.
   - Response: after that edge saida=0, valido=0, erro=0, sel_reg=0; after release, valido returns 2 edges later carrying D0.
6. Back-to-back loads.
   - Stimulus: controle=1 then controle=3 on consecutive edges, both with carrega=1.
   - Response: saida shows D1 and then D3 on consecutive cycles, each 2 edges after its load.
